float_to_fixed_pipe: RTL
========================

// Module: float_to_fixed_pipe
// PURPOSE
//   Pipelined IEEE-754 single-precision to sign-magnitude fixed-point converter with valid/ready handshake.
//   Generalises the combinational float decoder to parametrised integer/fraction widths, 1 result/cycle.
//   Adds saturation, NaN/Inf/denormal handling and status flags. Sits between float sources and fixed-point datapaths.
// PARAMETERS
//   INT_W   8  integer magnitude bits, legal 1..32
//   FRAC_W  8  fraction bits, legal 1..32
// PORTS
//   clk        in   1               single clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   in_valid   in   1               in_data valid
//   in_ready   out  1               converter accepts in_data this cycle
//   in_data    in   32              IEEE-754 binary32 {sign, exp[7:0], mant[22:0]}
//   out_valid  out  1               result valid
//   out_ready  in   1               downstream accepts result
//   out_sign   out  1               copy of input sign bit (also for -0, NaN)
//   out_int    out  INT_W           integer magnitude
//   out_frac   out  FRAC_W          fraction magnitude (weight of MSB is 2^-1)
//   out_ovf    out  1               magnitude saturated (|x| >= 2^INT_W, or Inf)
//   out_udf    out  1               nonzero finite input produced zero magnitude
//   out_nan    out  1               input was NaN
// BEHAVIOUR
//   - Reset: all stage valids and every output = 0; in_ready = 1 once reset is released.
//   - Three stages: S1 unpack/classify + shift amount; S2 alignment shift; S3 round/saturate/flag.
//   - Global advance en = !out_valid || out_ready; in_ready = en. Transfer on in_valid && in_ready.
//   - Latency 3 cycles from input transfer to out_valid; throughput 1/cycle while out_ready = 1.
//   - While out_valid && !out_ready: all stages hold, outputs stable, no data loss, order preserved.
//   - Normal (exp 1..254): mag = 1.mant * 2^(exp-127). Denormal (exp 0, mant != 0): mag = 0.mant * 2^-126.
//   - Zero (exp 0, mant 0): int = frac = 0, no flags, sign passed through.
//   - Inf (exp 255, mant 0): int/frac all ones, ovf = 1. NaN (exp 255, mant != 0): int = frac = 0, nan = 1.
//   - Alignment window 24+INT_W+FRAC_W bits. A left shift moving the leading 1 beyond bit INT_W-1 sets ovf.
//     A right shift past the window yields zero. Shift amounts are clamped; no wrap-around.
//   - Default rounding: truncate toward zero (magnitude discards bits below 2^-FRAC_W).
//   - ovf => int and frac are forced to all ones. udf is set only if input is finite, nonzero and result = 0.
//   - At most one of ovf/udf/nan is set per result.
//   - Reset asserted mid-stream: in-flight results dropped, no partial output after release.
// CONFIGURATION
//   FLOAT2FIX_ROUND_EN defined: S3 rounds the magnitude to nearest, ties to even, at the 2^-FRAC_W LSB.
//     A rounding carry into 2^INT_W saturates and sets ovf. A result rounded up from zero clears udf.
//   Undefined: truncation as above; no rounding logic is built. Latency is 3 in both builds.
// STRUCTURE
//   Package float2fix_pkg: EXP_W=8, MANT_W=23, EXP_BIAS=127, typedef fp_class_t {ZERO, DENORM, NORM, INF, NAN}.
//   Sub-module f2x_align_shift: parametrised bidirectional barrel shifter, S2 register included, with ovf detect.
//   Top holds S1/S3 logic, the valid chain and the stall enable.
// TESTING (INT_W=8, FRAC_W=8; out_ready=1 unless stated)
//   0x40490FDB (3.14159) -> sign 0, int 0x03, frac 0x24; out_valid exactly 3 cycles after transfer.
//   0xC2F6E979 (-123.456) -> sign 1, int 0x7B, frac 0x74 (0x75 with FLOAT2FIX_ROUND_EN).
//   0x43800000 (256.0) and 0x7F800000 (+Inf) -> int 0xFF, frac 0xFF, ovf 1.
//     0x7FC00000 (NaN) -> int 0, frac 0, nan 1.
//   0x3B000000 (2^-9) -> int 0, frac 0, udf 1 in both builds (tie to even).
//     0x80000000 -> sign 1, magnitude 0, no flags.
//   Backpressure: stream 6 back-to-back values, hold out_ready=0 for 4 cycles.
//     -> in_ready falls, outputs held stable, all 6 results delivered in order.
//   Pulse rst_n low for 1 cycle with 3 values in flight -> out_valid 0 and all outputs 0 immediately;
//     no stale output after reset is released.

Source files
------------

// File: rtl/float2fix_pkg.sv
// Shared types and constants for the binary32 to fixed-point converter.
package float2fix_pkg;

  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;
  localparam int SIG_W    = MANT_W + 1;

  typedef enum logic [2:0] {
    ZERO   = 3'd0,
    DENORM = 3'd1,
    NORM   = 3'd2,
    INF    = 3'd3,
    NAN    = 3'd4
  } fp_class_t;

  function automatic fp_class_t fp_classify(input logic [EXP_W-1:0] exp_f,
                                            input logic [MANT_W-1:0] mant_f);
    fp_class_t cls;
    if (exp_f == 8'd0) begin
      cls = (mant_f == 23'd0) ? ZERO : DENORM;
    end else if (exp_f == 8'hFF) begin
      cls = (mant_f == 23'd0) ? INF : NAN;
    end else begin
      cls = NORM;
    end
    return cls;
  endfunction

  // Round-to-nearest-even increment from the kept LSB, the guard bit and the sticky OR.
  function automatic logic round_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/f2x_align_shift.sv
// Stage-2 alignment: bidirectional barrel shift of the significand into the
// fixed-point window, registered, with detection of bits lost off the top.
module f2x_align_shift
  import float2fix_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          en,
  input  logic [SIG_W-1:0]                              sig,
  input  logic                                          shl,
  input  logic [$clog2(SIG_W+INT_W+FRAC_W+1)-1:0]       amt,
  output logic [SIG_W+INT_W+FRAC_W-1:0]                 win_r,
  output logic                                          ovf_r
);

  localparam int WIN_W = SIG_W + INT_W + FRAC_W;

  logic [2*WIN_W-1:0] wide_s;
  logic [WIN_W-1:0]   win_s;
  logic               ovf_s;

  // Shift left into a double-width field so anything pushed past the window top is visible.
  always_comb begin
    wide_s = {{WIN_W{1'b0}}, WIN_W'(sig)} << amt;
    if (shl) begin
      win_s = wide_s[WIN_W-1:0];
      ovf_s = |wide_s[2*WIN_W-1:WIN_W];
    end else begin
      win_s = WIN_W'(sig) >> amt;
      ovf_s = 1'b0;
    end
  end

  // Stage-2 register, held while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_r <= {WIN_W{1'b0}};
      ovf_r <= 1'b0;
    end else if (en) begin
      win_r <= win_s;
      ovf_r <= ovf_s;
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// Three-stage binary32 to sign-magnitude fixed-point converter with valid/ready.
// Optional build macro FLOAT2FIX_ROUND_EN selects round-to-nearest-even instead of truncation.
module float_to_fixed_pipe
  import float2fix_pkg::*;
#(
  parameter int INT_W  = 8,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic [INT_W-1:0]  out_int,
  output logic [FRAC_W-1:0] out_frac,
  output logic              out_ovf,
  output logic              out_udf,
  output logic              out_nan
);

  localparam int WIN_W = SIG_W + INT_W + FRAC_W;
  localparam int AMT_W = $clog2(WIN_W + 1);
  localparam int MAG_W = INT_W + FRAC_W;

  logic en_s;

  fp_class_t        cls_s;
  logic [EXP_W-1:0] exp_eff_s;
  logic [SIG_W-1:0] sig_s;
  logic [11:0]      sh_s;
  logic [11:0]      sh_abs_s;
  logic [AMT_W-1:0] amt_s;

  logic             v1_r, sign1_r, shl1_r;
  fp_class_t        cls1_r;
  logic [SIG_W-1:0] sig1_r;
  logic [AMT_W-1:0] amt1_r;

  logic             v2_r, sign2_r;
  fp_class_t        cls2_r;
  logic [WIN_W-1:0] win2_r;
  logic             aovf2_r;

  logic [MAG_W:0]   rnd_s;
  logic [MAG_W-1:0] mag_s;
  logic             ovf_s, udf_s, nan_s;

  logic              out_valid_r, out_sign_r, out_ovf_r, out_udf_r, out_nan_r;
  logic [INT_W-1:0]  out_int_r;
  logic [FRAC_W-1:0] out_frac_r;

  assign en_s     = !out_valid_r || out_ready;
  assign in_ready = en_s;

  // S1: classify and turn the exponent into a clamped shift toward the window.
  // The window LSB weighs 2^-(FRAC_W+SIG_W), so the left shift is e + 1 + FRAC_W.
  always_comb begin
    cls_s     = fp_classify(in_data[30:23], in_data[22:0]);
    exp_eff_s = 8'd1;
    sig_s     = {SIG_W{1'b0}};
    case (cls_s)
      NORM: begin
        exp_eff_s = in_data[30:23];
        sig_s     = {1'b1, in_data[22:0]};
      end
      DENORM: begin
        exp_eff_s = 8'd1;
        sig_s     = {1'b0, in_data[22:0]};
      end
      default: begin
        exp_eff_s = 8'd1;
        sig_s     = {SIG_W{1'b0}};
      end
    endcase
    sh_s     = 12'(exp_eff_s) - 12'(EXP_BIAS) + 12'(FRAC_W) + 12'd1;
    sh_abs_s = sh_s[11] ? (12'd0 - sh_s) : sh_s;
    if (sh_abs_s > 12'(WIN_W)) begin
      amt_s = AMT_W'(WIN_W);
    end else begin
      amt_s = AMT_W'(sh_abs_s);
    end
  end

  // S1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r    <= 1'b0;
      sign1_r <= 1'b0;
      shl1_r  <= 1'b0;
      cls1_r  <= ZERO;
      sig1_r  <= {SIG_W{1'b0}};
      amt1_r  <= {AMT_W{1'b0}};
    end else if (en_s) begin
      v1_r    <= in_valid;
      sign1_r <= in_data[31];
      shl1_r  <= !sh_s[11];
      cls1_r  <= cls_s;
      sig1_r  <= sig_s;
      amt1_r  <= amt_s;
    end
  end

  f2x_align_shift #(
    .INT_W  (INT_W),
    .FRAC_W (FRAC_W)
  ) u_align (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en_s),
    .sig   (sig1_r),
    .shl   (shl1_r),
    .amt   (amt1_r),
    .win_r (win2_r),
    .ovf_r (aovf2_r)
  );

  // S2 sideband travelling alongside the shifted window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      sign2_r <= 1'b0;
      cls2_r  <= ZERO;
    end else if (en_s) begin
      v2_r    <= v1_r;
      sign2_r <= sign1_r;
      cls2_r  <= cls1_r;
    end
  end

`ifdef FLOAT2FIX_ROUND_EN
  // Bits below the kept LSB: guard at SIG_W-1, sticky below it.
  assign rnd_s = {1'b0, win2_r[WIN_W-1:SIG_W]}
               + {{MAG_W{1'b0}}, round_up(win2_r[SIG_W], win2_r[SIG_W-1], |win2_r[SIG_W-2:0])};
`else
  logic unused_low_s;
  assign unused_low_s = ^win2_r[SIG_W-1:0];
  assign rnd_s        = {1'b0, win2_r[WIN_W-1:SIG_W]};
`endif

  // S3: special classes, saturation and underflow flagging.
  always_comb begin
    mag_s = {MAG_W{1'b0}};
    ovf_s = 1'b0;
    udf_s = 1'b0;
    nan_s = 1'b0;
    case (cls2_r)
      NAN: begin
        nan_s = 1'b1;
      end
      INF: begin
        mag_s = {MAG_W{1'b1}};
        ovf_s = 1'b1;
      end
      NORM, DENORM: begin
        if (aovf2_r || rnd_s[MAG_W]) begin
          mag_s = {MAG_W{1'b1}};
          ovf_s = 1'b1;
        end else begin
          mag_s = rnd_s[MAG_W-1:0];
          udf_s = (rnd_s[MAG_W-1:0] == {MAG_W{1'b0}});
        end
      end
      default: begin
        mag_s = {MAG_W{1'b0}};
      end
    endcase
  end

  // S3 output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_sign_r  <= 1'b0;
      out_int_r   <= {INT_W{1'b0}};
      out_frac_r  <= {FRAC_W{1'b0}};
      out_ovf_r   <= 1'b0;
      out_udf_r   <= 1'b0;
      out_nan_r   <= 1'b0;
    end else if (en_s) begin
      out_valid_r <= v2_r;
      out_sign_r  <= sign2_r;
      out_int_r   <= mag_s[MAG_W-1:FRAC_W];
      out_frac_r  <= mag_s[FRAC_W-1:0];
      out_ovf_r   <= ovf_s;
      out_udf_r   <= udf_s;
      out_nan_r   <= nan_s;
    end
  end

  assign out_valid = out_valid_r;
  assign out_sign  = out_sign_r;
  assign out_int   = out_int_r;
  assign out_frac  = out_frac_r;
  assign out_ovf   = out_ovf_r;
  assign out_udf   = out_udf_r;
  assign out_nan   = out_nan_r;

endmodule
